// File: rtl/cpu_pkg.sv
// Shared CPU definitions: execute-stage FSM states, PC constants and comparator op codes
// so that the decoder, comparator and branch/PC unit all agree on the same encodings.
package cpu_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pc_state_t;

  localparam int PC_INC = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LT  = 3'd2,
    CMP_GE  = 3'd3,
    CMP_LTU = 3'd4,
    CMP_GEU = 3'd5
  } cmp_op_t;

  // A fetch address is word aligned when its two low bits are clear.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return |low_bits;
  endfunction

endpackage

// File: rtl/branch_pc_unit_if.sv
// Execute-stage control/fetch bundle between the pipeline (master) and the branch/PC unit (slave).
interface branch_pc_unit_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic              br_valid;
  logic [ADDR_W-1:0] br_pc;
  logic [ADDR_W-1:0] br_offset;
  logic              compout;
  logic              jmp_valid;
  logic [ADDR_W-1:0] jmp_target;
  logic [ADDR_W-1:0] pc;
  logic              redirect;
  logic              flush;
  logic              align_err;

  modport master (
    output stall, br_valid, br_pc, br_offset, compout, jmp_valid, jmp_target,
    input  pc, redirect, flush, align_err
  );

  modport slave (
    input  stall, br_valid, br_pc, br_offset, compout, jmp_valid, jmp_target,
    output pc, redirect, flush, align_err
  );
endinterface

// File: rtl/branch_target_adder.sv
// Combinational redirect target: jump target or br_pc + 4 + offset, word-aligned,
// with a flag for a target whose low bits were not zero.
module branch_target_adder
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_jmp_valid,
  input  logic [ADDR_W-1:0] i_jmp_target,
  input  logic [ADDR_W-1:0] i_br_pc,
  input  logic [ADDR_W-1:0] i_br_offset,
  output logic [ADDR_W-1:0] o_target,
  output logic              o_misaligned
);

  logic [ADDR_W-1:0] w_br_target;
  logic [ADDR_W-1:0] w_raw_target;

  // Jump wins over a simultaneous branch; the sum wraps modulo 2^ADDR_W.
  assign w_br_target  = i_br_pc + ADDR_W'(PC_INC) + i_br_offset;
  assign w_raw_target = i_jmp_valid ? i_jmp_target : w_br_target;

  assign o_target     = {w_raw_target[ADDR_W-1:2], 2'b00};
  assign o_misaligned = is_misaligned(w_raw_target[1:0]);

endmodule

// File: rtl/branch_pc_unit.sv
// Execute-stage branch resolution and architectural PC: advances by 4 or redirects to a
// resolved target, then squashes FLUSH_SLOTS wrong-path slots via the flush output.
module branch_pc_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEFAULT_RESET_PC),
  parameter int                FLUSH_SLOTS = 2
) (
  input  logic           clock,
  input  logic           reset,
  branch_pc_unit_if.slave bus
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_SLOTS);

  pc_state_t         r_state;
  logic [2:0]        r_cnt;
  logic [ADDR_W-1:0] r_pc;
  logic              r_redirect;
  logic              r_flush;
  logic              r_align_err;

  logic [ADDR_W-1:0] w_target;
  logic              w_misaligned;
  logic              w_take;

  branch_target_adder #(
    .ADDR_W(ADDR_W)
  ) u_target (
    .i_jmp_valid (bus.jmp_valid),
    .i_jmp_target(bus.jmp_target),
    .i_br_pc     (bus.br_pc),
    .i_br_offset (bus.br_offset),
    .o_target    (w_target),
    .o_misaligned(w_misaligned)
  );

  // Control-flow inputs in FLUSH belong to squashed instructions, so only RUN may redirect.
  assign w_take = (bus.jmp_valid | (bus.br_valid & bus.compout)) &
                  (r_state == RUN) & ~bus.stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_redirect  <= 1'b0;
      r_flush     <= 1'b0;
      r_align_err <= 1'b0;
      r_state     <= RUN;
      r_cnt       <= 3'd0;
    end else if (!bus.stall) begin
      if (w_take) begin
        r_pc        <= w_target;
        r_redirect  <= 1'b1;
        r_align_err <= w_misaligned;
        if (FLUSH_SLOTS > 0) begin
          r_state <= FLUSH;
          r_cnt   <= FLUSH_LOAD;
          r_flush <= 1'b1;
        end
      end else begin
        r_pc        <= r_pc + ADDR_W'(PC_INC);
        r_redirect  <= 1'b0;
        r_align_err <= 1'b0;
        // flush tracks the next state so it drops on the same edge FLUSH ends.
        if (r_state == FLUSH) begin
          if (r_cnt == 3'd1) begin
            r_state <= RUN;
            r_cnt   <= 3'd0;
            r_flush <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
      end
    end
  end

  assign bus.pc        = r_pc;
  assign bus.redirect  = r_redirect;
  assign bus.flush     = r_flush;
  assign bus.align_err = r_align_err;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Bench for branch_pc_unit: directed vector table from the test plan, then randomized
// cycles checked against a cycle-level behavioural model of PC/redirect/flush.
module tb_branch_pc_unit;

  localparam int          FLUSH_SLOTS = 2;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;

  typedef struct {
    bit          rst;
    bit          stall;
    bit          bv;
    logic [31:0] bpc;
    logic [31:0] boff;
    bit          cmp;
    bit          jv;
    logic [31:0] jt;
    logic [31:0] ePc;
    bit          eRed;
    bit          eFlush;
    bit          eAlign;
  } vec_t;

  logic clock;
  logic reset;
  int   checkCount;
  int   errorCount;

  branch_pc_unit_if #(.ADDR_W(32)) bus ();

  branch_pc_unit #(
    .ADDR_W     (32),
    .RESET_PC   (RESET_PC),
    .FLUSH_SLOTS(FLUSH_SLOTS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state: the PC, and how many squash cycles remain.
  logic [31:0] mPc;
  bit          mRed;
  bit          mAlign;
  int          mFlushLeft;

  task automatic modelStep(input vec_t v);
    logic [31:0] target;
    bit          taken;
    if (v.rst) begin
      mPc        = RESET_PC;
      mRed       = 0;
      mAlign     = 0;
      mFlushLeft = 0;
    end else if (!v.stall) begin
      taken = (mFlushLeft == 0) && (v.jv || (v.bv && v.cmp));
      if (mFlushLeft > 0) mFlushLeft--;
      if (taken) begin
        target     = v.jv ? v.jt : v.bpc + 32'd4 + v.boff;
        mPc        = target & ~32'd3;
        mAlign     = (target % 4) != 0;
        mRed       = 1;
        mFlushLeft = FLUSH_SLOTS;
      end else begin
        mPc    = mPc + 32'd4;
        mRed   = 0;
        mAlign = 0;
      end
    end
  endtask

  // Drives one cycle of inputs and returns #1 after the capturing edge.
  task automatic applyStimulus(input vec_t v);
    reset          = v.rst;
    bus.stall      = v.stall;
    bus.br_valid   = v.bv;
    bus.br_pc      = v.bpc;
    bus.br_offset  = v.boff;
    bus.compout    = v.cmp;
    bus.jmp_valid  = v.jv;
    bus.jmp_target = v.jt;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input int idx, input logic [31:0] ePc, input bit eRed,
                             input bit eFlush, input bit eAlign);
    checkCount++;
    if (bus.pc !== ePc) begin
      errorCount++;
      $display("[TB] FAIL pc step %0d: got %h expected %h", idx, bus.pc, ePc);
    end
    checkCount++;
    if (bus.redirect !== eRed) begin
      errorCount++;
      $display("[TB] FAIL redirect step %0d: got %b expected %b", idx, bus.redirect, eRed);
    end
    checkCount++;
    if (bus.flush !== eFlush) begin
      errorCount++;
      $display("[TB] FAIL flush step %0d: got %b expected %b", idx, bus.flush, eFlush);
    end
    checkCount++;
    if (bus.align_err !== eAlign) begin
      errorCount++;
      $display("[TB] FAIL align_err step %0d: got %b expected %b", idx, bus.align_err, eAlign);
    end
  endtask

  function automatic vec_t mk(bit rst, bit stall, bit bv, logic [31:0] bpc, logic [31:0] boff,
                              bit cmp, bit jv, logic [31:0] jt, logic [31:0] ePc,
                              bit eRed, bit eFlush, bit eAlign);
    vec_t v;
    v.rst = rst;  v.stall = stall; v.bv = bv;   v.bpc = bpc; v.boff = boff;
    v.cmp = cmp;  v.jv = jv;       v.jt = jt;   v.ePc = ePc; v.eRed = eRed;
    v.eFlush = eFlush; v.eAlign = eAlign;
    return v;
  endfunction

  vec_t vecs[$];
  vec_t rv;

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset          = 1'b1;
    bus.stall      = 1'b0;
    bus.br_valid   = 1'b0;
    bus.br_pc      = '0;
    bus.br_offset  = '0;
    bus.compout    = 1'b0;
    bus.jmp_valid  = 1'b0;
    bus.jmp_target = '0;

    //          rst st bv bpc           boff     c  jv jt            ePc           red fl al
    vecs.push_back(mk(1, 0, 0, 0,            0,       0, 0, 0,            32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,            0,       0, 0, 0,            32'h4,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,            0,       0, 0, 0,            32'h8,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,            0,       0, 0, 0,            32'hC,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,            0,       0, 0, 0,            32'h10,       0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h10,       32'h20,  1, 0, 0,            32'h34,       1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,            0,       0, 0, 0,            32'h38,       0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,            0,       0, 0, 0,            32'h3C,       0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h10,       32'h20,  0, 0, 0,            32'h40,       0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h10,       32'h20,  1, 1, 32'h100,      32'h100,      1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'h100,      32'h40,  1, 0, 0,            32'h104,      0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'h104,      32'h40,  1, 0, 0,            32'h108,      0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFF8, 32'h8,  1, 0, 0,            32'h4,        1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 32'h40,       32'h40,  1, 0, 0,            32'h4,        1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0,            0,       0, 1, 32'h300,      32'h4,        1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0,            0,       0, 0, 0,            32'h4,        1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,            0,       0, 0, 0,            32'h8,        0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,            0,       0, 0, 0,            32'hC,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,            0,       0, 1, 32'h102,      32'h100,      1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0,            0,       0, 0, 0,            32'h104,      0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0,            0,       0, 0, 0,            32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,            0,       0, 0, 0,            32'h4,        0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,            0,       0, 1, 32'h200,      32'h4,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,            0,       0, 0, 0,            32'h8,        0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h20,       32'hFFFF_FFE2, 1, 0, 0,      32'h4,        1, 1, 1));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i].ePc, vecs[i].eRed, vecs[i].eFlush, vecs[i].eAlign);
    end

    // Randomized cycles against the model, starting from a reset.
    rv = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    modelStep(rv);
    applyStimulus(rv);
    checkOutput(1000, mPc, mRed, (mFlushLeft > 0), mAlign);
    for (int n = 0; n < 500; n++) begin
      rv.rst   = ($urandom_range(0, 59) == 0);
      rv.stall = ($urandom_range(0, 4) == 0);
      rv.bv    = ($urandom_range(0, 2) == 0);
      rv.cmp   = $urandom_range(0, 1) == 1;
      rv.jv    = ($urandom_range(0, 7) == 0);
      rv.bpc   = $urandom & ~32'd3;
      rv.boff  = 32'($urandom_range(0, 1023)) - 32'd512;
      if ($urandom_range(0, 3) != 0) rv.boff = rv.boff & ~32'd3;
      rv.jt    = $urandom;
      if ($urandom_range(0, 3) != 0) rv.jt = rv.jt & ~32'd3;
      modelStep(rv);
      applyStimulus(rv);
      checkOutput(1001 + n, mPc, mRed, (mFlushLeft > 0), mAlign);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
